// File: rtl/ks_pkg.sv
// Shared types and helpers for the sequential Kogge-Stone adder.
// Holds the controller state encoding and the prefix-level distance function.
package ks_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PREFIX = 2'd1,
        DONE   = 2'd2
    } ks_state_e;

    // Span of one Kogge-Stone level: level s combines bit i with bit i-2^s.
    function automatic int unsigned ks_dist(input int unsigned stage);
        return 32'd1 << stage;
    endfunction

endpackage

// File: rtl/ks_gp_cell.sv
// Per-bit generate/propagate cell.
// Ports: a, b operand bits; g = a&b (generate); p = a^b (propagate).
module ks_gp_cell (
    input  logic a,
    input  logic b,
    output logic g,
    output logic p
);

    assign g = a & b;
    assign p = a ^ b;

endmodule

// File: rtl/ks_prefix_level.sv
// One Kogge-Stone prefix level of black cells, selected by a stage index.
// Ports: g_in/pg_in current group G/P; stage level index; g_out/pg_out next G/P.
module ks_prefix_level
    import ks_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SW    = 3
) (
    input  logic [WIDTH-1:0] g_in,
    input  logic [WIDTH-1:0] pg_in,
    input  logic [SW-1:0]    stage,
    output logic [WIDTH-1:0] g_out,
    output logic [WIDTH-1:0] pg_out
);

    logic [WIDTH-1:0] g_sh;
    logic [WIDTH-1:0] pg_sh;
    logic [WIDTH-1:0] hi_mask;

    // Shifting by the level distance lines bit i-d up with bit i.
    // Low bits (i<d) see zero in g_sh, so G holds there for free;
    // hi_mask forces their Pg to hold as well.
    always_comb begin
        g_sh    = g_in << ks_dist(32'(stage));
        pg_sh   = pg_in << ks_dist(32'(stage));
        hi_mask = {WIDTH{1'b1}} << ks_dist(32'(stage));
        g_out   = g_in | (pg_in & g_sh);
        pg_out  = pg_in & (pg_sh | ~hi_mask);
    end

endmodule

// File: rtl/ks_seq_adder_ctrl.sv
// Multi-cycle Kogge-Stone adder: one prefix level reused over log2(WIDTH)
// cycles, operands in and result out over valid/ready handshakes.
// Ports: CLK, RST_N (sync, active-low); IN_VALID/IN_READY with A, B, CIN;
//        OUT_VALID/OUT_READY with SUM, COUT; BUSY high in PREFIX or DONE.
module ks_seq_adder_ctrl
    import ks_pkg::*;
#(
    parameter  int WIDTH  = 16,
    localparam int NSTAGE = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT,
    output logic             BUSY
);

    // Counter must reach NSTAGE without wrapping; keep at least one bit.
    localparam int SW = (NSTAGE > 0) ? $clog2(NSTAGE + 1) : 1;

    ks_state_e        state_r;
    logic [WIDTH-1:0] g_r;
    logic [WIDTH-1:0] pg_r;
    logic [WIDTH-1:0] p_r;
    logic [WIDTH-1:0] sum_r;
    logic             cin_r;
    logic             cout_r;
    logic [SW-1:0]    stage_r;

    logic [WIDTH-1:0] gen_w;
    logic [WIDTH-1:0] prop_w;
    logic [WIDTH-1:0] g_load;
    logic [WIDTH-1:0] g_nx;
    logic [WIDTH-1:0] pg_nx;
    logic [WIDTH-1:0] sum_pf;
    logic             cout_pf;
    logic [WIDTH-1:0] sum_ld;
    logic             cout_ld;
    logic             last_stage;
    logic             accept;

    for (genvar i = 0; i < WIDTH; i++) begin : g_gp
        ks_gp_cell u_gp (
            .a (A[i]),
            .b (B[i]),
            .g (gen_w[i]),
            .p (prop_w[i])
        );
    end

    // Carry-in is treated as a generate into bit 0, so after the
    // final level G_r[i] is the carry out of bit i.
    always_comb begin
        g_load    = gen_w;
        g_load[0] = gen_w[0] | (prop_w[0] & CIN);
    end

    ks_prefix_level #(
        .WIDTH (WIDTH),
        .SW    (SW)
    ) u_level (
        .g_in   (g_r),
        .pg_in  (pg_r),
        .stage  (stage_r),
        .g_out  (g_nx),
        .pg_out (pg_nx)
    );

    // Carry into bit i is G of bit i-1; bit 0 takes the carry-in.
    // The result is formed from the level output so the last level
    // and the sum land on the same edge.
    assign sum_pf  = p_r ^ WIDTH'({g_nx, cin_r});
    assign cout_pf = g_nx[WIDTH-1];

    // Direct path used only when there are no prefix levels (WIDTH=1).
    assign sum_ld  = prop_w ^ WIDTH'({g_load, CIN});
    assign cout_ld = g_load[WIDTH-1];

    assign last_stage = (stage_r == SW'(NSTAGE - 1));

    assign IN_READY  = (state_r == IDLE);
    assign OUT_VALID = (state_r == DONE);
    assign BUSY      = (state_r != IDLE);
    assign SUM       = sum_r;
    assign COUT      = cout_r;
    assign accept    = IN_VALID && IN_READY;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r <= IDLE;
            g_r     <= '0;
            pg_r    <= '0;
            p_r     <= '0;
            cin_r   <= 1'b0;
            stage_r <= '0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
        end else begin
            unique case (state_r)
                IDLE: begin
                    if (accept) begin
                        p_r     <= prop_w;
                        pg_r    <= prop_w;
                        g_r     <= g_load;
                        cin_r   <= CIN;
                        stage_r <= '0;
                        if (NSTAGE == 0) begin
                            sum_r   <= sum_ld;
                            cout_r  <= cout_ld;
                            state_r <= DONE;
                        end else begin
                            state_r <= PREFIX;
                        end
                    end
                end
                PREFIX: begin
                    g_r     <= g_nx;
                    pg_r    <= pg_nx;
                    stage_r <= stage_r + SW'(1);
                    if (last_stage) begin
                        sum_r   <= sum_pf;
                        cout_r  <= cout_pf;
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    if (OUT_READY) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ks_seq_adder_ctrl.sv
// Directed and random bench for ks_seq_adder_ctrl at WIDTH 16, 12 and 1.
// Each comparison is an immediate assertion; one summary line at the end.
module tb_ks_seq_adder_ctrl;

    logic clk;
    logic rst_n;

    logic        iv16, ir16, ov16, or16, ci16, co16, bz16;
    logic [15:0] a16, b16, s16;
    logic        iv12, ir12, ov12, or12, ci12, co12, bz12;
    logic [11:0] a12, b12, s12;
    logic        iv1, ir1, ov1, or1, ci1, co1, bz1;
    logic [0:0]  a1, b1, s1;

    int n_chk;
    int n_fail;

    ks_seq_adder_ctrl #(.WIDTH(16)) u16 (
        .CLK(clk), .RST_N(rst_n),
        .IN_VALID(iv16), .IN_READY(ir16),
        .A(a16), .B(b16), .CIN(ci16),
        .OUT_VALID(ov16), .OUT_READY(or16),
        .SUM(s16), .COUT(co16), .BUSY(bz16)
    );

    ks_seq_adder_ctrl #(.WIDTH(12)) u12 (
        .CLK(clk), .RST_N(rst_n),
        .IN_VALID(iv12), .IN_READY(ir12),
        .A(a12), .B(b12), .CIN(ci12),
        .OUT_VALID(ov12), .OUT_READY(or12),
        .SUM(s12), .COUT(co12), .BUSY(bz12)
    );

    ks_seq_adder_ctrl #(.WIDTH(1)) u1 (
        .CLK(clk), .RST_N(rst_n),
        .IN_VALID(iv1), .IN_READY(ir1),
        .A(a1), .B(b1), .CIN(ci1),
        .OUT_VALID(ov1), .OUT_READY(or1),
        .SUM(s1), .COUT(co1), .BUSY(bz1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic ov_of(input int w);
        case (w)
            16:      return ov16;
            12:      return ov12;
            default: return ov1;
        endcase
    endfunction

    function automatic logic [16:0] res_of(input int w);
        case (w)
            16:      return {co16, s16};
            12:      return 17'({co12, s12});
            default: return 17'({co1, s1});
        endcase
    endfunction

    // One transaction with OUT_READY high; lat counts edges from the
    // accepting edge until OUT_VALID is seen (bounded).
    task automatic do_op(input int w,
                         input logic [15:0] a,
                         input logic [15:0] b,
                         input logic c,
                         output logic [16:0] res,
                         output int lat);
        case (w)
            16: begin
                a16 = a; b16 = b; ci16 = c; iv16 = 1'b1;
            end
            12: begin
                a12 = a[11:0]; b12 = b[11:0]; ci12 = c; iv12 = 1'b1;
            end
            default: begin
                a1 = a[0]; b1 = b[0]; ci1 = c; iv1 = 1'b1;
            end
        endcase
        @(posedge clk); #1;
        iv16 = 1'b0; iv12 = 1'b0; iv1 = 1'b0;
        lat = 0;
        while (!ov_of(w) && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        res = res_of(w);
        @(posedge clk); #1;
        chk("valid_one_cycle", 32'(ov_of(w)), 32'd0);
    endtask

    logic [16:0] res;
    logic [16:0] exp;
    logic [15:0] ra, rb;
    logic        rc;
    int          lat;
    int          cyc, k, r, tmo;
    logic        acc, seen;
    int          acc_t [4];
    logic [15:0] ops_a [4];
    logic [15:0] ops_b [4];

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst_n = 1'b0;
        iv16 = 0; or16 = 1; a16 = '0; b16 = '0; ci16 = 0;
        iv12 = 0; or12 = 1; a12 = '0; b12 = '0; ci12 = 0;
        iv1 = 0; or1 = 1; a1 = '0; b1 = '0; ci1 = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(ir16), 32'd1);
        chk("rst_out_valid", 32'(ov16), 32'd0);
        chk("rst_sum", 32'(s16), 32'd0);
        chk("rst_cout", 32'(co16), 32'd0);
        chk("rst_busy", 32'(bz16), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_in_ready", 32'(ir16), 32'd1);

        // Single add, latency and pulse width
        do_op(16, 16'h00FF, 16'h0001, 1'b0, res, lat);
        chk("t1_sum", 32'(res), 32'h0_0100);
        chk("t1_latency", 32'(lat), 32'd4);

        // Full-length propagate chains
        do_op(16, 16'hFFFF, 16'h0000, 1'b1, res, lat);
        chk("t2_prop_chain", 32'(res), 32'h1_0000);
        do_op(16, 16'hFFFF, 16'hFFFF, 1'b1, res, lat);
        chk("t2_all_ones", 32'(res), 32'h1_FFFF);

        // Backpressure: result must hold, new operands dropped
        or16 = 1'b0;
        a16 = 16'h1111; b16 = 16'h2222; ci16 = 1'b0; iv16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0;
        tmo = 0;
        while (!ov16 && tmo < 20) begin
            @(posedge clk); #1;
            tmo++;
        end
        chk("t3_valid_seen", 32'(ov16), 32'd1);
        for (int i = 0; i < 6; i++) begin
            a16 = 16'hA5A5 + 16'(i); b16 = 16'h0F0F; iv16 = 1'b1;
            @(posedge clk); #1;
            chk("t3_hold_valid", 32'(ov16), 32'd1);
            chk("t3_hold_sum", 32'({co16, s16}), 32'h0_3333);
            chk("t3_in_ready_low", 32'(ir16), 32'd0);
        end
        iv16 = 1'b0;
        or16 = 1'b1;
        @(posedge clk); #1;
        chk("t3_release_valid", 32'(ov16), 32'd0);
        chk("t3_release_ready", 32'(ir16), 32'd1);
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            seen = seen | ov16;
        end
        chk("t3_no_queued_op", 32'(seen), 32'd0);

        // Reset while stage == 2
        a16 = 16'h0F0F; b16 = 16'h0101; ci16 = 1'b1; iv16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t4_busy_mid", 32'(bz16), 32'd1);
        chk("t4_ready_mid", 32'(ir16), 32'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("t4_state_idle", 32'(ir16), 32'd1);
        chk("t4_valid", 32'(ov16), 32'd0);
        chk("t4_sum", 32'(s16), 32'd0);
        chk("t4_busy", 32'(bz16), 32'd0);
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            seen = seen | ov16;
        end
        chk("t4_no_pulse", 32'(seen), 32'd0);
        do_op(16, 16'h1234, 16'h4321, 1'b0, res, lat);
        chk("t4_after_reset", 32'(res), 32'h0_5555);

        // Back-to-back with IN_VALID and OUT_READY held high
        ops_a[0] = 16'h0001; ops_b[0] = 16'h0002;
        ops_a[1] = 16'h8000; ops_b[1] = 16'h8000;
        ops_a[2] = 16'h7FFF; ops_b[2] = 16'h0001;
        ops_a[3] = 16'hABCD; ops_b[3] = 16'h1111;
        cyc = 0; k = 0; r = 0;
        a16 = ops_a[0]; b16 = ops_b[0]; ci16 = 1'b0; iv16 = 1'b1;
        while (r < 4 && cyc < 60) begin
            acc = iv16 && ir16;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                acc_t[k] = cyc;
                k++;
                if (k < 4) begin
                    a16 = ops_a[k]; b16 = ops_b[k];
                end else begin
                    iv16 = 1'b0;
                end
            end
            if (ov16) begin
                exp = 17'(ops_a[r]) + 17'(ops_b[r]);
                chk("t5_result", 32'({co16, s16}), 32'(exp));
                r++;
            end
        end
        iv16 = 1'b0;
        chk("t5_results_count", 32'(r), 32'd4);
        chk("t5_accept_count", 32'(k), 32'd4);
        for (int i = 1; i < 4; i++) begin
            chk("t5_spacing", 32'(acc_t[i] - acc_t[i-1]), 32'd6);
        end
        @(posedge clk); #1;

        // Directed corner cases at the other widths
        do_op(12, 16'h0FFF, 16'h0001, 1'b0, res, lat);
        chk("w12_span", 32'(res), 32'h0_1000);
        do_op(1, 16'h0001, 16'h0001, 1'b1, res, lat);
        chk("w1_all_ones", 32'(res), 32'h0_0003);
        chk("w1_valid_first_cycle", 32'(lat), 32'd0);

        // Random vectors against A+B+CIN
        for (int i = 0; i < 2000; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            rc = 1'($urandom);
            do_op(16, ra, rb, rc, res, lat);
            exp = 17'(ra) + 17'(rb) + 17'(rc);
            chk("rnd16", 32'(res), 32'(exp));
        end
        for (int i = 0; i < 2000; i++) begin
            ra = 16'($urandom_range(0, 4095));
            rb = 16'($urandom_range(0, 4095));
            rc = 1'($urandom);
            do_op(12, ra, rb, rc, res, lat);
            exp = 17'(ra) + 17'(rb) + 17'(rc);
            chk("rnd12", 32'(res), 32'(exp));
        end
        for (int i = 0; i < 2000; i++) begin
            ra = 16'($urandom_range(0, 1));
            rb = 16'($urandom_range(0, 1));
            rc = 1'($urandom);
            do_op(1, ra, rb, rc, res, lat);
            exp = 17'(ra) + 17'(rb) + 17'(rc);
            chk("rnd1", 32'(res), 32'(exp));
            chk("rnd1_latency", 32'(lat), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
